// File: rtl/aes_axis_in.sv
// aes_axis_in: AXI-Stream front end for aes_top.
//
// Frames arrive as one command beat followed by BLK_S/WORD_S payload beats.
// The first payload beat lands in the most significant word of the block.
// A valid command (CTRL_KEY or CTRL_ENCRYPT) loads the collected block into
// aes_key or aes_plaintext and strobes en for one cycle. The block then
// waits for core_done before it accepts the next frame.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tlast   input stream from DMA
//   s_axis_tready               stream ready (IDLE or DATA, low during reset)
//   ctrl                        latched command to aes_top
//   aes_key, aes_plaintext      registered block outputs
//   en                          one-cycle start strobe
//   core_done                   completion pulse from aes_top
//   busy                        high while the block is issued or in flight
//   err                         one-cycle protocol error pulse
//
// Build option: define AES_AXIS_TLAST_CHECK_EN to enforce tlast framing.
// Without it, tlast is ignored and frames are delimited by beat count only.
//
// state   | meaning
// ST_IDLE | await command beat
// ST_DATA | collect payload beats
// ST_FIRE | en high, block issued
// ST_WAIT | wait for core_done

module aes_axis_in #(
   parameter int                 WORD_S       = 32,
   parameter int                 BLK_S        = 128,
   parameter int                 KEY_S        = 128,
   parameter int                 CTRL_S       = 2,
   parameter logic [CTRL_S-1:0]  CTRL_KEY     = 2'd1,
   parameter logic [CTRL_S-1:0]  CTRL_ENCRYPT = 2'd2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_S-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tlast,
   output logic              s_axis_tready,
   output logic [CTRL_S-1:0] ctrl,
   output logic [KEY_S-1:0]  aes_key,
   output logic [BLK_S-1:0]  aes_plaintext,
   output logic              en,
   input  logic              core_done,
   output logic              busy,
   output logic              err
);

   localparam int BEATS = BLK_S / WORD_S;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_FIRE, ST_WAIT} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [BLK_S-1:0]   hold;
   logic [BLK_S-1:0]   hold_next;
   logic [CTRL_S-1:0]  ctrl_prev;
   logic               discard;
   logic               beat;
   logic               last_beat;
   logic               cmd_ok;
   logic               tl_early;
   logic               tl_missing;

`ifdef AES_AXIS_TLAST_CHECK_EN
   assign tl_early   = s_axis_tlast;
   assign tl_missing = ~s_axis_tlast;
`else
   logic unused_tlast;
   assign unused_tlast = s_axis_tlast;
   assign tl_early     = 1'b0;
   assign tl_missing   = 1'b0;
`endif

   assign s_axis_tready = ~reset & ((state == ST_IDLE) | (state == ST_DATA));
   assign busy          = (state == ST_FIRE) | (state == ST_WAIT);
   assign beat          = s_axis_tvalid & s_axis_tready;
   assign last_beat     = (cnt == LAST_CNT);
   assign cmd_ok        = (s_axis_tdata[CTRL_S-1:0] == CTRL_KEY) |
                          (s_axis_tdata[CTRL_S-1:0] == CTRL_ENCRYPT);
   // MSB-first: each new beat pushes earlier beats toward the top word.
   assign hold_next     = {hold[BLK_S-WORD_S-1:0], s_axis_tdata};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         hold          <= '0;
         ctrl          <= '0;
         ctrl_prev     <= '0;
         discard       <= 1'b0;
         aes_key       <= '0;
         aes_plaintext <= '0;
         en            <= 1'b0;
         err           <= 1'b0;
      end else begin
         en  <= 1'b0;
         err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (beat) begin
                  if (tl_early) begin
                     err <= 1'b1;
                  end else begin
                     cnt   <= '0;
                     state <= ST_DATA;
                     if (cmd_ok) begin
                        ctrl_prev <= ctrl;
                        ctrl      <= s_axis_tdata[CTRL_S-1:0];
                        discard   <= 1'b0;
                     end else begin
                        err     <= 1'b1;
                        discard <= 1'b1;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (beat) begin
                  hold <= hold_next;
                  if (tl_early && !last_beat) begin
                     // Short frame: drop it and undo the command latch.
                     err   <= ~discard;
                     cnt   <= '0;
                     state <= ST_IDLE;
                     if (!discard) ctrl <= ctrl_prev;
                  end else if (last_beat) begin
                     cnt <= '0;
                     if (discard) begin
                        state <= ST_IDLE;
                     end else begin
                        if (ctrl == CTRL_KEY) aes_key       <= KEY_S'(hold_next);
                        else                  aes_plaintext <= hold_next;
                        en    <= 1'b1;
                        err   <= tl_missing;
                        state <= ST_FIRE;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            ST_FIRE: state <= ST_WAIT;
            ST_WAIT: if (core_done) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_axis_in.sv
module tb_aes_axis_in;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [31:0]  s_axis_tdata = '0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tlast = 1'b0;
   logic         s_axis_tready;
   logic [1:0]   ctrl;
   logic [127:0] aes_key;
   logic [127:0] aes_plaintext;
   logic         en;
   logic         core_done = 1'b0;
   logic         busy;
   logic         err;

   int errors = 0;
   int checks = 0;
   int en_cnt = 0;
   int err_cnt = 0;

   localparam logic [31:0]  CMD_KEY = 32'h0000_0001;
   localparam logic [31:0]  CMD_ENC = 32'h0000_0002;
   localparam logic [127:0] KEY1 = 128'h5468617473206D79204B756E67204675;
   localparam logic [127:0] PT1  = 128'h54776F204F6E65204E696E652054776F;
   localparam logic [127:0] KEY2 = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] KEY3 = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;

   aes_axis_in dut (
      .clk           (clk),
      .reset         (reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .ctrl          (ctrl),
      .aes_key       (aes_key),
      .aes_plaintext (aes_plaintext),
      .en            (en),
      .core_done     (core_done),
      .busy          (busy),
      .err           (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (en)  en_cnt++;
      if (err) err_cnt++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until the handshake edge.
   task automatic send_beat(input logic [31:0] d, input logic l);
      int n = 0;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      while (!s_axis_tready && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) begin
         check("tready_timeout", 0, 1);
      end else begin
         step();
      end
   endtask

   task automatic send_frame(input logic [31:0] cmd, input logic [127:0] pay,
                             input int last_at, input int nbeats, input bit gap);
      logic [31:0] d;
      for (int i = 0; i < nbeats; i++) begin
         d = (i == 0) ? cmd : pay[127 - 32*(i-1) -: 32];
         send_beat(d, i == last_at);
         if (gap && i < nbeats - 1) begin
            s_axis_tvalid = 1'b0;
            step();
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic finish_core();
      core_done = 1'b1;
      step();
      core_done = 1'b0;
   endtask

   initial begin
      int e0, r0;
      step(); step(); step();
      check("rst_tready", s_axis_tready, 0);
      check("rst_busy",   busy, 0);
      check("rst_en",     en, 0);
      check("rst_err",    err, 0);
      check("rst_ctrl",   ctrl, 0);
      check("rst_key",    aes_key, 0);
      check("rst_pt",     aes_plaintext, 0);
      reset = 1'b0;
      #1;
      check("post_rst_tready", s_axis_tready, 1);

      // core_done while idle has no effect
      finish_core();
      check("idle_done_tready", s_axis_tready, 1);
      check("idle_done_busy",   busy, 0);

      // key frame
      e0 = en_cnt;
      send_frame(CMD_KEY, KEY1, 4, 5, 0);
      check("key_en",      en, 1);
      check("key_busy",    busy, 1);
      check("key_tready",  s_axis_tready, 0);
      check("key_value",   aes_key, KEY1);
      check("key_ctrl",    ctrl, 1);
      check("key_pt_hold", aes_plaintext, 0);
      step();
      check("key_en_drop", en, 0);
      step(); step();
      check("wait_busy",   busy, 1);
      check("wait_tready", s_axis_tready, 0);
      check("wait_key",    aes_key, KEY1);
      finish_core();
      check("done_tready", s_axis_tready, 1);
      check("done_busy",   busy, 0);
      check("key_en_cnt",  en_cnt - e0, 1);

      // encrypt frame
      send_frame(CMD_ENC, PT1, 4, 5, 0);
      check("enc_en",   en, 1);
      check("enc_pt",   aes_plaintext, PT1);
      check("enc_key",  aes_key, KEY1);
      check("enc_ctrl", ctrl, 2);
      step();
      finish_core();

      // invalid command: consumed and discarded
      e0 = en_cnt; r0 = err_cnt;
      send_frame(32'hFFFF_FFFF, KEY3, 4, 5, 0);
      step();
      check("bad_err_cnt", err_cnt - r0, 1);
      check("bad_en_cnt",  en_cnt - e0, 0);
      check("bad_tready",  s_axis_tready, 1);
      check("bad_key",     aes_key, KEY1);
      check("bad_pt",      aes_plaintext, PT1);
      check("bad_ctrl",    ctrl, 2);

      // reset mid-frame, then a complete key frame
      e0 = en_cnt;
      send_frame(CMD_KEY, KEY3, 9, 3, 0);
      reset = 1'b1;
      #1;
      check("midrst_tready", s_axis_tready, 0);
      step(); step();
      check("midrst_key", aes_key, 0);
      reset = 1'b0;
      #1;
      check("midrst_tready_up", s_axis_tready, 1);
      send_frame(CMD_KEY, KEY2, 4, 5, 0);
      check("midrst_new_key", aes_key, KEY2);
      step();
      check("midrst_en_cnt", en_cnt - e0, 1);
      finish_core();

      // early tlast on payload beat 2
      e0 = en_cnt; r0 = err_cnt;
`ifdef AES_AXIS_TLAST_CHECK_EN
      send_frame(CMD_KEY, KEY3, 2, 3, 0);
      step();
      check("tlast_err_cnt", err_cnt - r0, 1);
      check("tlast_en_cnt",  en_cnt - e0, 0);
      check("tlast_key",     aes_key, KEY2);
      check("tlast_ctrl",    ctrl, 2'd1);
      check("tlast_tready",  s_axis_tready, 1);
`else
      send_frame(CMD_KEY, KEY3, 2, 5, 0);
      check("tlast_en",      en, 1);
      check("tlast_key",     aes_key, KEY3);
      step();
      check("tlast_err_cnt", err_cnt - r0, 0);
      check("tlast_en_cnt",  en_cnt - e0, 1);
      finish_core();
`endif

      // tvalid toggling every cycle
      e0 = en_cnt;
      send_frame(CMD_ENC, KEY2, 4, 5, 1);
      check("gap_en",   en, 1);
      check("gap_pt",   aes_plaintext, KEY2);
      check("gap_ctrl", ctrl, 2);
      step();
      check("gap_en_cnt", en_cnt - e0, 1);
      finish_core();
      check("gap_tready", s_axis_tready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
